// File: rtl/mips_trace_buffer_pkg.sv
// Shared types for the MIPS trace buffer: FSM states, the stored entry layout,
// and the pointer-width helper used to size buffer addresses.
package mips_trace_pkg;

    localparam int TRACE_W    = 32;
    localparam int TRACE_TS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    // Field order matches the packed word held in trace_ram at default widths.
    typedef struct packed {
        logic [TRACE_W-1:0]    pc;
        logic [TRACE_W-1:0]    alu;
        logic [TRACE_W-1:0]    wd;
        logic [TRACE_TS_W-1:0] ts;
    } trace_entry_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Observation, control and readout bundle between the MIPS core side and the
// trace buffer.
interface mips_trace_buffer_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
);
    localparam int AW = mips_trace_pkg::ptr_w(DEPTH);

    logic             arm;
    logic             trig_en;
    logic [WIDTH-1:0] trig_pc;
    logic             force_trig;
    logic             sample_valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] alu_out;
    logic [WIDTH-1:0] write_data;
    logic [AW-1:0]    rd_addr;

    logic             busy;
    logic             done;
    logic [AW:0]      valid_count;
    logic [AW-1:0]    trig_index;
    logic [WIDTH-1:0] rd_pc;
    logic [WIDTH-1:0] rd_alu;
    logic [WIDTH-1:0] rd_wd;
    logic [TS_W-1:0]  rd_ts;

    modport master (
        output arm, trig_en, trig_pc, force_trig, sample_valid,
               pc, alu_out, write_data, rd_addr,
        input  busy, done, valid_count, trig_index, rd_pc, rd_alu, rd_wd, rd_ts
    );

    modport slave (
        input  arm, trig_en, trig_pc, force_trig, sample_valid,
               pc, alu_out, write_data, rd_addr,
        output busy, done, valid_count, trig_index, rd_pc, rd_alu, rd_wd, rd_ts
    );

endinterface

// File: rtl/mips_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, one synchronous read port.
module trace_ram #(
    parameter int DW    = 112,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // No reset: contents are fenced off by the caller's valid count instead.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_trace_buffer.sv
// Trace capture beside the MIPS core: rolling PC/ALU/store-data history with a
// post-trigger window, frozen in DONE for random-access readout.
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 8,
    parameter int TS_W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    mips_trace_buffer_if.slave bus
);
    localparam int AW     = ptr_w(DEPTH);
    localparam int CW     = AW + 1;
    localparam int EW     = 3 * WIDTH + TS_W;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [CW-1:0] WINDOW    = CW'(DEPTH - PRE_TRIG);
    localparam logic [CW-1:0] POST_LAST = CW'(POST_N);

    trace_state_e    state_q;
    logic            busy_q;
    logic            done_q;
    logic            pend_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   trig_index_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   post_q;
    logic [TS_W-1:0] ts_q;
    logic            rd_ok_q;

    logic            capture;
    logic            hit;
    logic [CW-1:0]   count_d;
    logic [CW-1:0]   post_d;
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   rd_ptr;
    logic [EW-1:0]   wr_entry;
    logic [EW-1:0]   rd_entry;

    always_comb begin
        capture = bus.sample_valid && !bus.arm &&
                  ((state_q == ST_ARMED) || (state_q == ST_POST));
        hit     = (bus.trig_en && (bus.pc == bus.trig_pc)) || bus.force_trig || pend_q;
        count_d = (count_q == FULL) ? count_q : count_q + 1'b1;
        post_d  = post_q + 1'b1;
        // Once the ring has wrapped, the next slot to overwrite is the oldest.
        oldest  = (count_q == FULL) ? wr_ptr_q : '0;
        rd_ptr  = oldest + bus.rd_addr;
    end

    assign wr_entry = {bus.pc, bus.alu_out, bus.write_data, ts_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pend_q       <= 1'b0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            post_q       <= '0;
            ts_q         <= '0;
            trig_index_q <= '0;
        end else if (bus.arm) begin
            state_q      <= ST_ARMED;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pend_q       <= 1'b0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            post_q       <= '0;
            ts_q         <= '0;
            trig_index_q <= '0;
        end else begin
            if (busy_q && (ts_q != '1)) begin
                ts_q <= ts_q + 1'b1;
            end
            if (capture) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                count_q  <= count_d;
            end
            case (state_q)
                ST_ARMED: begin
                    if (bus.sample_valid && hit) begin
                        pend_q <= 1'b0;
                        if (POST_N == 0) begin
                            state_q      <= ST_DONE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            trig_index_q <= AW'(count_d - WINDOW);
                        end else begin
                            state_q <= ST_POST;
                            post_q  <= '0;
                        end
                    end else if (!bus.sample_valid && bus.force_trig) begin
                        pend_q <= 1'b1;
                    end
                end
                ST_POST: begin
                    if (bus.sample_valid) begin
                        post_q <= post_d;
                        if (post_d == POST_LAST) begin
                            state_q      <= ST_DONE;
                            busy_q       <= 1'b0;
                            done_q       <= 1'b1;
                            trig_index_q <= AW'(count_d - WINDOW);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Readout gate shares the RAM's one-cycle latency so data and mask line up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ok_q <= 1'b0;
        end else begin
            rd_ok_q <= (state_q == ST_DONE) && ({1'b0, bus.rd_addr} < count_q);
        end
    end

    trace_ram #(
        .DW    (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (capture),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr),
        .rdata_o (rd_entry)
    );

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.valid_count = count_q;
    assign bus.trig_index  = trig_index_q;
    assign {bus.rd_pc, bus.rd_alu, bus.rd_wd, bus.rd_ts} = rd_ok_q ? rd_entry : '0;

endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Parametrised on-chip trace capture for the pipelined MIPS core. It records a rolling history of PC, ALU result and store data, plus a cycle timestamp, into a circular buffer. It stops a programmable number of samples after a PC-match or forced trigger, then exposes the window for random-access readout. It sits beside the core and replaces waveform dumping for long runs and for post-silicon debug.

## Interface
- `WIDTH`, 32, datapath width of PC/ALUOut/WriteData
- `DEPTH`, 16, buffer entries; power of two, ≥4
- `PRE_TRIG`, 8, max samples kept before trigger; 1 ≤ PRE_TRIG ≤ DEPTH-1
- `TS_W`, 16, timestamp width

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `arm`  in  1  pulse: clear and start capture
- `trig_en`  in  1  enable PC-match trigger
- `trig_pc`  in  WIDTH  PC value that fires trigger
- `force_trig`  in  1  unconditional trigger pulse
- `sample_valid`  in  1  current pc/alu_out/write_data are a retired sample
- `pc`, `alu_out`, `write_data`  in  WIDTH each  core observation points
- `rd_addr`  in  $clog2(DEPTH)  readout index, 0 = oldest
- `busy`  out  1  high in ARMED or POST
- `done`  out  1  high in DONE
- `valid_count`  out  $clog2(DEPTH)+1  entries held
- `trig_index`  out  $clog2(DEPTH)  readout index of trigger sample
- `rd_pc`, `rd_alu`, `rd_wd`  out  WIDTH  readout data
- `rd_ts`  out  TS_W  readout timestamp

## Operation
- States: IDLE, ARMED, POST, DONE. Reset → IDLE, all outputs 0.
- `arm` in any state → ARMED next cycle; clears wr_ptr, sample count, post count, timestamp. `arm` wins over any trigger in the same cycle.
- ARMED: each `sample_valid` cycle writes {pc, alu_out, write_data, ts} at wr_ptr; wr_ptr wraps mod DEPTH. Total count saturates at DEPTH.
- Trigger = `sample_valid && ((trig_en && pc==trig_pc) || force_trig)`, evaluated in ARMED only. The triggering sample is written, then the block enters POST.
- `force_trig` without `sample_valid` is held pending and fires on the next valid sample. The pending flag is cleared by `arm`.
- POST: captures exactly DEPTH-PRE_TRIG-1 further valid samples. Triggers are ignored. Then → DONE.
- DONE: writes stop. Holds until `arm` or `rst`.
- Oldest entry = wr_ptr if count==DEPTH, else 0. Readout address = (oldest + rd_addr) mod DEPTH.
- `valid_count` = min(total samples, DEPTH).
- `trig_index` = valid_count − (DEPTH − PRE_TRIG). It is computed and registered on entry to DONE.
- An early trigger (fewer than PRE_TRIG pre-samples) is legal and yields a smaller `trig_index` and `valid_count`.
- `ts`: 0 on arm, +1 every clock while busy, saturates at all-ones.
- Reading with rd_addr ≥ valid_count, or outside DONE, returns all-zero data.

## Timing
- Sample written on the edge where `sample_valid` is high; `busy` deasserts the cycle after the final POST write.
- `done` and `trig_index` are valid in the same cycle as each other.
- Readout latency is 1 cycle: rd_* reflect the rd_addr of the previous edge.
- `rst` mid-capture immediately forces IDLE and zero outputs. Buffer contents need not be cleared, but must be unreadable (count=0).
- Simultaneous trigger and the last slot wrapping is not a special case: the wrap is silent.

## Structure
- `mips_trace_pkg`: `trace_state_e` enum, `trace_entry_t` struct {pc, alu, wd, ts}, and a clog2-based pointer-width helper.
- Sub-module `trace_ram`: simple dual-port, 1 write / 1 synchronous read, DEPTH × entry width. The FSM, pointers and counters stay in the top level.

## Test plan
Defaults DEPTH=16, PRE_TRIG=8.
- Normal trigger: arm, pc=0,4,8,… every cycle, trig_pc=0x40 → done after 24th sample; valid_count=16; trig_index=8; rd_addr 0..15 gives pc 0x20..0x5C, ts 8..23.
- Early trigger: trig_pc=0x08 → 10 samples total; valid_count=10; trig_index=2; rd_addr 10 returns zeros.
- Gapped samples: sample_valid every other cycle, force_trig on the 20th sample → stored ts values step by 2, 7 post samples captured.
- Arm and force_trig in the same cycle → force ignored; block is ARMED with count 0; later trig_pc match works.
- `rst` asserted in POST → next edge shows busy=0, done=0, valid_count=0; re-arm completes a normal capture.
- Re-arm in POST → capture restarts with ts=0, valid_count=0, and the previous trigger is discarded.
